// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// funct codes, ALU control and datapath mux select values.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ERROR   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcen;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       fault;
    } ctrl_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// R-type funct to ALU control decode; unknown funct codes flag illegal and
// fall back to the AND code.
module mips_alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       funct_legal
);

    always_comb begin
        alucontrol  = ALU_AND;
        funct_legal = 1'b1;
        case (funct)
            F_ADD:   alucontrol = ALU_ADD;
            F_SUB:   alucontrol = ALU_SUB;
            F_AND:   alucontrol = ALU_AND;
            F_OR:    alucontrol = ALU_OR;
            F_SLT:   alucontrol = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory ready handshake, wait timeout and
// sticky fault state. Define MIPS_CTRL_BNE_EN to accept bne (op 000101).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       fault,
    output logic [3:0] state_o
);

`ifdef MIPS_CTRL_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(MEM_TIMEOUT);

    state_t           state, state_nx;
    logic [CNT_W-1:0] wcnt;
    logic [2:0]       funct_alu;
    logic             funct_legal;
    logic             mem_st, timeout;
    ctrl_t            c;

    mips_alu_decode u_alu_decode (
        .funct       (funct),
        .alucontrol  (funct_alu),
        .funct_legal (funct_legal)
    );

    assign mem_st  = is_mem_state(state);
    assign timeout = (MEM_TIMEOUT != 0) && mem_st && !mem_ready && (wcnt == TO_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nx;
    end

    // Counts consecutive stalled cycles; any non-stalled cycle clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  wcnt <= '0;
        else if (mem_st && !mem_ready) wcnt <= (&wcnt) ? wcnt : wcnt + 1'b1;
        else                        wcnt <= '0;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:   if (mem_ready) state_nx = S_DECODE;
                       else if (timeout) state_nx = S_ERROR;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nx = S_MEMADR;
                    OP_RTYPE:     state_nx = S_EXECUTE;
                    OP_BEQ:       state_nx = S_BRANCH;
                    OP_BNE:       state_nx = BNE_EN ? S_BRANCH : S_ERROR;
                    OP_ADDI:      state_nx = S_ADDIEX;
                    OP_J:         state_nx = S_JUMP;
                    default:      state_nx = S_ERROR;
                endcase
            end
            S_MEMADR:  state_nx = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_nx = S_MEMWB;
                       else if (timeout) state_nx = S_ERROR;
            S_MEMWR:   if (mem_ready) state_nx = S_FETCH;
                       else if (timeout) state_nx = S_ERROR;
            S_EXECUTE: state_nx = funct_legal ? S_ALUWB : S_ERROR;
            S_ADDIEX:  state_nx = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_nx = S_FETCH;
            S_ERROR:   state_nx = S_ERROR;
            default:   state_nx = S_ERROR;
        endcase
    end

    always_comb begin
        c = '0;
        case (state)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.alusrcb    = SRCB_FOUR;
                c.alucontrol = ALU_ADD;
                c.irwrite    = mem_ready;
                c.pcen       = mem_ready;
            end
            S_DECODE: begin
                c.alusrcb    = SRCB_IMMSH;
                c.alucontrol = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = SRCB_IMM;
                c.alucontrol = ALU_ADD;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_req  = 1'b1;
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = SRCB_RT;
                c.alucontrol = funct_alu;
            end
            S_ALUWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = SRCB_RT;
                c.alucontrol = ALU_SUB;
                c.pcsrc      = PCSRC_ALUOUT;
                c.pcen       = (BNE_EN && op == OP_BNE) ? ~zero : zero;
            end
            S_ADDIWB: c.regwrite = 1'b1;
            S_JUMP: begin
                c.pcsrc = PCSRC_JUMP;
                c.pcen  = 1'b1;
            end
            S_ERROR: c.fault = 1'b1;
            default: ;
        endcase
    end

    // Strobes are held off during reset; the rest already show FETCH values.
    assign mem_req    = c.mem_req  & ~reset;
    assign memwrite   = c.memwrite & ~reset;
    assign irwrite    = c.irwrite  & ~reset;
    assign pcen       = c.pcen     & ~reset;
    assign regwrite   = c.regwrite & ~reset;
    assign iord       = c.iord;
    assign regdst     = c.regdst;
    assign memtoreg   = c.memtoreg;
    assign alusrca    = c.alusrca;
    assign alusrcb    = c.alusrcb;
    assign pcsrc      = c.pcsrc;
    assign alucontrol = c.alucontrol;
    assign fault      = c.fault;
    assign state_o    = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed and randomized instruction streams checked against a per-instruction
// phase model of the multicycle control FSM.
module tb_mips_multicycle_ctrl;

    localparam int TO = 4;
`ifdef MIPS_CTRL_BNE_EN
    localparam bit BNE = 1'b1;
`else
    localparam bit BNE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca, fault;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state_o;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .fault(fault), .state_o(state_o)
    );

    always #5 clk = ~clk;

    wire [16:0] obs_v = {mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg,
                         alusrca, alusrcb, pcsrc, alucontrol, fault};

    int         n_cmp = 0, n_bad = 0, ncyc = 0, last_len = 0, force_zero = -1;
    logic [5:0] cur_op = 6'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int alu_ref(input logic [5:0] f);
        case (f)
            6'b100000: return 2;
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b101010: return 7;
            default:   return -1;
        endcase
    endfunction

    // Instruction class: 0 lw, 1 sw, 2 R-type, 3 branch, 4 addi, 5 j, 6 illegal
    function automatic int cls(input logic [5:0] o);
        case (o)
            6'b100011: return 0;
            6'b101011: return 1;
            6'b000000: return 2;
            6'b000100: return 3;
            6'b000101: return BNE ? 3 : 6;
            6'b001000: return 4;
            6'b000010: return 5;
            default:   return 6;
        endcase
    endfunction

    // Expected control word for a given phase, from the per-state output table.
    function automatic logic [16:0] exp_vec(input int st, input bit rdy, input bit z,
                                            input logic [5:0] o, input logic [5:0] f);
        logic mr = 0, io = 0, mw = 0, ir = 0, pe = 0, rw = 0, rd = 0, mt = 0, sa = 0, flt = 0;
        logic [1:0] sb = 0, ps = 0;
        logic [2:0] ac = 0;
        int a;
        case (st)
            0:  begin mr = 1; sb = 2'd1; ac = 3'd2; ir = rdy; pe = rdy; end
            1:  begin sb = 2'd3; ac = 3'd2; end
            2:  begin sa = 1; sb = 2'd2; ac = 3'd2; end
            3:  begin mr = 1; io = 1; end
            4:  begin rw = 1; mt = 1; end
            5:  begin mr = 1; io = 1; mw = 1; end
            6:  begin sa = 1; a = alu_ref(f); ac = (a < 0) ? 3'd0 : 3'(a); end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; ac = 3'd6; ps = 2'd1; pe = (BNE && o == 6'b000101) ? !z : z; end
            9:  begin sa = 1; sb = 2'd2; ac = 3'd2; end
            10: rw = 1;
            11: begin ps = 2'd2; pe = 1; end
            15: flt = 1;
            default: ;
        endcase
        return {mr, io, mw, ir, pe, rw, rd, mt, sa, sb, ps, ac, flt};
    endfunction

    // Called just after a falling edge; returns at the next falling edge.
    task automatic cycle(input int st, input bit rdy);
        mem_ready = rdy;
        op        = (st == 0) ? 6'($urandom) : cur_op;
        zero      = (force_zero < 0) ? 1'($urandom) : 1'(force_zero);
        #1;
        chk("state", 32'(state_o), 32'(st));
        chk("outputs", 32'(obs_v), 32'(exp_vec(st, rdy, zero, op, funct)));
        ncyc++;
        @(negedge clk);
    endtask

    task automatic mem_phase(input int st, input int w, output bit dead);
        dead = 0;
        for (int i = 0; ; i++) begin
            bit r = (i == w);
            cycle(st, r);
            if (r) break;
            if (i == TO) begin dead = 1; break; end
        end
    endtask

    task automatic do_reset();
        reset = 1; mem_ready = 1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("rst_state", 32'(state_o), 32'd0);
            chk("rst_outputs", 32'(obs_v), 32'(exp_vec(0, 1, zero, op, funct) & 17'h0CFFF));
            @(negedge clk);
        end
        reset = 0;
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input int w0, input int w1, input int hold);
        bit dead;
        int t0 = ncyc;
        cur_op = o; funct = f;
        mem_phase(0, w0, dead);
        if (!dead) begin
            cycle(1, 1'($urandom));
            case (cls(o))
                0: begin cycle(2, 1'($urandom)); mem_phase(3, w1, dead); if (!dead) cycle(4, 1'($urandom)); end
                1: begin cycle(2, 1'($urandom)); mem_phase(5, w1, dead); end
                2: begin cycle(6, 1'($urandom)); if (alu_ref(f) >= 0) cycle(7, 1'($urandom)); else dead = 1; end
                3: cycle(8, 1'($urandom));
                4: begin cycle(9, 1'($urandom)); cycle(10, 1'($urandom)); end
                5: cycle(11, 1'($urandom));
                default: dead = 1;
            endcase
        end
        last_len = ncyc - t0;
        if (dead) begin
            repeat (hold) cycle(15, 1'($urandom));
            do_reset();
        end
    endtask

    initial begin
        logic [5:0] ops [8];
        logic [5:0] fns [5];
        bit d;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        reset = 1; op = 0; funct = 0; zero = 0; mem_ready = 0;
        @(negedge clk);
        do_reset();

        run_instr(6'b000000, 6'b100000, 0, 0, 3);
        chk("rtype_len", 32'(last_len), 32'd4);
        run_instr(6'b100011, 6'b000000, 0, 3, 3);
        chk("lw_wait_len", 32'(last_len), 32'd8);
        run_instr(6'b101011, 6'b000000, 0, 0, 3);
        chk("sw_len", 32'(last_len), 32'd4);
        force_zero = 1; run_instr(6'b000100, 6'b000000, 0, 0, 3);
        chk("beq_t_len", 32'(last_len), 32'd3);
        force_zero = 0; run_instr(6'b000100, 6'b000000, 0, 0, 3);
        chk("beq_nt_len", 32'(last_len), 32'd3);
        force_zero = -1;
        run_instr(6'b001000, 6'b000000, 0, 0, 3);
        chk("addi_len", 32'(last_len), 32'd4);
        run_instr(6'b000010, 6'b000000, 0, 0, 3);
        chk("j_len", 32'(last_len), 32'd3);
        run_instr(6'b111111, 6'b100000, 0, 0, 20);
        run_instr(6'b000000, 6'b000000, 0, 0, 20);
        run_instr(6'b000000, 6'b100000, TO + 1, 0, 3);
        chk("fetch_timeout_len", 32'(last_len), 32'(TO + 1));
        run_instr(6'b000000, 6'b100010, TO, 0, 3);
        chk("fetch_late_ready_len", 32'(last_len), 32'(TO + 4));
        run_instr(6'b101011, 6'b000000, 0, TO + 1, 3);
        force_zero = 0; run_instr(6'b000101, 6'b000000, 0, 0, 3); force_zero = -1;

        // Reset asserted while a load is stalled in MEMRD.
        cur_op = 6'b100011;
        mem_phase(0, 0, d); cycle(1, 1'b0); cycle(2, 1'b0); cycle(3, 1'b0); cycle(3, 1'b0);
        do_reset();
        run_instr(6'b000000, 6'b101010, 0, 0, 3);
        chk("post_reset_len", 32'(last_len), 32'd4);

        for (int n = 0; n < 400; n++) begin
            logic [5:0] o = ops[$urandom_range(0, 7)];
            logic [5:0] f = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            int w0 = ($urandom_range(0, 19) == 0) ? TO + 1 : $urandom_range(0, 3);
            int w1 = ($urandom_range(0, 19) == 0) ? TO + 1 : $urandom_range(0, TO);
            if (o == 6'b111111) o = 6'($urandom);
            run_instr(o, f, w0, w1, $urandom_range(1, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
